// File: rtl/axicb_pkg.sv
// rtl/axicb_pkg.sv - shared types and helpers for the crossbar channel blocks
package axicb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Widest requester vector the round-robin core supports.
  localparam int OH_MAX = 8;

  // One-hot to binary index; returns 0 for an all-zero vector.
  function automatic logic [2:0] onehot2bin(input logic [OH_MAX-1:0] oh);
    logic [2:0] b;
    b = '0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (oh[i]) b = b | 3'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/axicb_round_robin_core.sv
// rtl/axicb_round_robin_core.sv - masked round-robin grant with advance-on-enable
module axicb_round_robin_core #(
  parameter int REQ_NB = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic              en,
  input  logic [REQ_NB-1:0] req,
  output logic [REQ_NB-1:0] grant
);

  logic [REQ_NB-1:0] mask_q;
  logic [REQ_NB-1:0] masked;
  logic [REQ_NB-1:0] mask_nxt;

  assign masked = req & mask_q;

  // Lowest requester above the last winner; wrap to the lowest requester overall.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < REQ_NB; i++) begin
      if (!found && masked[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < REQ_NB; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Next mask keeps only the positions strictly above the current grant.
  always_comb begin
    logic seen;
    mask_nxt = '0;
    seen     = 1'b0;
    for (int i = 0; i < REQ_NB; i++) begin
      mask_nxt[i] = seen;
      seen        = seen | grant[i];
    end
  end

  // Mask advances only when the granted transfer completes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mask_q <= '1;
    end else if (srst) begin
      mask_q <= '1;
    end else if (en && (|grant)) begin
      mask_q <= mask_nxt;
    end
  end

endmodule

// File: rtl/axicb_burst_lock_mux.sv
// rtl/axicb_burst_lock_mux.sv - round-robin stream mux that holds the grant for a whole burst
module axicb_burst_lock_mux #(
  parameter int REQ_NB = 4,
  parameter int DATA_W = 64,
  parameter int ID_W   = (REQ_NB > 1) ? $clog2(REQ_NB) : 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     srst,
  input  logic [REQ_NB-1:0]        i_valid,
  output logic [REQ_NB-1:0]        i_ready,
  input  logic [REQ_NB*DATA_W-1:0] i_data,
  input  logic [REQ_NB-1:0]        i_last,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_last,
  output logic [ID_W-1:0]          o_id,
  output logic                     busy
);

  import axicb_pkg::*;

  state_t            state;
  logic [REQ_NB-1:0] sel_q;
  logic [ID_W-1:0]   id_q;

  logic [REQ_NB-1:0] rr_req;
  logic [REQ_NB-1:0] grant;
  logic [ID_W-1:0]   grant_id;
  logic [REQ_NB-1:0] sel;
  logic [ID_W-1:0]   sel_id;
  logic              hs_last;

  // While locked the core sees only the owner, so its grant mirrors sel_q
  // and its mask advances past the owner when the burst ends.
  assign rr_req  = (state == LOCKED) ? sel_q : i_valid;
  assign hs_last = o_valid & o_ready & o_last;

  axicb_round_robin_core #(
    .REQ_NB (REQ_NB)
  ) u_rr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .en      (hs_last),
    .req     (rr_req),
    .grant   (grant)
  );

  assign grant_id = ID_W'(onehot2bin(OH_MAX'(grant)));

  assign sel    = (state == LOCKED) ? sel_q : grant;
  assign sel_id = (state == LOCKED) ? id_q  : grant_id;

  // Zero-latency AND-OR payload mux; all zero when nothing is selected.
  always_comb begin
    o_data = '0;
    o_last = 1'b0;
    for (int k = 0; k < REQ_NB; k++) begin
      if (sel[k]) begin
        o_data = o_data | i_data[k*DATA_W +: DATA_W];
        o_last = o_last | i_last[k];
      end
    end
  end

  assign o_valid = |(sel & i_valid);
  assign i_ready = sel & {REQ_NB{o_ready}};
  assign o_id    = (REQ_NB == 1) ? '0 : sel_id;
  assign busy    = (state == LOCKED);

  // Lock on the first beat that does not close the burst; release on the last beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      sel_q <= '0;
      id_q  <= '0;
    end else if (srst) begin
      state <= IDLE;
      sel_q <= '0;
      id_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((|i_valid) && !hs_last) begin
            state <= LOCKED;
            sel_q <= grant;
            id_q  <= grant_id;
          end
        end
        LOCKED: begin
          if (hs_last) begin
            state <= IDLE;
            sel_q <= '0;
          end
        end
        default: begin
          state <= IDLE;
          sel_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axicb_burst_lock_mux.sv
// tb/tb_axicb_burst_lock_mux.sv - directed scoreboard bench for the burst-lock mux
module tb_axicb_burst_lock_mux;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic            srst;
  logic [N-1:0]    i_valid;
  logic [N-1:0]    i_ready;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]    i_last;
  logic            o_valid;
  logic            o_ready;
  logic [DW-1:0]   o_data;
  logic            o_last;
  logic [IW-1:0]   o_id;
  logic            busy;

  axicb_burst_lock_mux #(
    .REQ_NB (N),
    .DATA_W (DW),
    .ID_W   (IW)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_id    (o_id),
    .busy    (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t sb[$];
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [63:0] d, input logic l);
    beat_t b;
    b.id   = IW'(id);
    b.data = d;
    b.last = l;
    sb.push_back(b);
  endtask

  task automatic drive(input int k, input logic v, input logic [63:0] d, input logic l);
    i_valid[k]          = v;
    i_data[k*DW +: DW]  = d;
    i_last[k]           = l;
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  // Every accepted output beat must match the oldest expected beat.
  always @(negedge aclk) begin
    if (aresetn && !srst && o_valid && o_ready) begin
      tests++;
      assert (sb.size() != 0)
      else begin
        fails++;
        $error("FAIL sb_unexpected_beat observed id=%0h data=%0h expected=none", o_id, o_data);
      end
      if (sb.size() != 0) begin
        beat_t e;
        e = sb.pop_front();
        check("beat_id", o_id, e.id);
        check("beat_data", o_data, e.data);
        check("beat_last", o_last, e.last);
      end
    end
  end

  int lonely_exp[7] = '{0, 1, 0, 1, 0, 1, 2};

  initial begin
    aresetn = 1'b0;
    srst    = 1'b0;
    i_valid = '0;
    i_data  = '0;
    i_last  = '0;
    o_ready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_i_ready", i_ready, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_last", o_last, 0);
    check("rst_o_id", o_id, 0);
    check("rst_busy", busy, 0);
    aresetn = 1'b1;
    next_cycle();

    // Fairness: all four single-beat, ready always high.
    for (int k = 0; k < N; k++) drive(k, 1'b1, 64'h100 + k, 1'b1);
    o_ready = 1'b1;
    for (int c = 0; c < 6; c++) push(c % 4, 64'h100 + (c % 4), 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      check("fair_id", o_id, c % 4);
      check("fair_busy", busy, 0);
      next_cycle();
    end
    i_valid = '0;

    // Burst lock: stream 1 four beats, stream 0 joins at beat 2.
    for (int b = 1; b <= 4; b++) push(1, 64'h1_0000 + b, b == 4);
    push(0, 64'hA0, 1'b1);
    push(1, 64'h1_0005, 1'b1);
    for (int b = 1; b <= 4; b++) begin
      drive(1, 1'b1, 64'h1_0000 + b, b == 4);
      if (b == 2) drive(0, 1'b1, 64'hA0, 1'b1);
      @(negedge aclk);
      check("lock_id", o_id, 1);
      check("lock_ready0", i_ready[0], 0);
      check("lock_busy", busy, b > 1);
      next_cycle();
    end
    drive(1, 1'b1, 64'h1_0005, 1'b1);
    @(negedge aclk);
    check("lock_next_id", o_id, 0);
    check("lock_next_busy", busy, 0);
    next_cycle();
    drive(0, 1'b0, 64'h0, 1'b0);
    @(negedge aclk);
    check("lock_after_id", o_id, 1);
    next_cycle();
    i_valid = '0;

    // Backpressure: stream 2 stalled three cycles, stream 3 arrives meanwhile.
    o_ready = 1'b0;
    drive(2, 1'b1, 64'hA5, 1'b1);
    push(2, 64'hA5, 1'b1);
    push(3, 64'h33, 1'b1);
    @(negedge aclk);
    check("bp_data0", o_data, 64'hA5);
    check("bp_id0", o_id, 2);
    check("bp_busy0", busy, 0);
    next_cycle();
    drive(3, 1'b1, 64'h33, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge aclk);
      check("bp_data", o_data, 64'hA5);
      check("bp_id", o_id, 2);
      check("bp_busy", busy, 1);
      check("bp_ready", i_ready, 0);
      next_cycle();
    end
    o_ready = 1'b1;
    @(negedge aclk);
    check("bp_accept_id", o_id, 2);
    next_cycle();
    drive(2, 1'b0, 64'h0, 1'b0);
    @(negedge aclk);
    check("bp_next_id", o_id, 3);
    next_cycle();
    i_valid = '0;

    // Lonely requests: 0011, then 0111 after a grant to 0.
    drive(0, 1'b1, 64'h200, 1'b1);
    drive(1, 1'b1, 64'h201, 1'b1);
    for (int c = 0; c < 7; c++) push(lonely_exp[c], 64'h200 + lonely_exp[c], 1'b1);
    for (int c = 0; c < 7; c++) begin
      if (c == 5) drive(2, 1'b1, 64'h202, 1'b1);
      @(negedge aclk);
      check("lonely_id", o_id, lonely_exp[c]);
      next_cycle();
    end
    i_valid = '0;

    // Synchronous reset mid-burst on stream 2.
    for (int b = 1; b <= 2; b++) push(2, 64'h300 + b, 1'b0);
    for (int b = 1; b <= 2; b++) begin
      drive(2, 1'b1, 64'h300 + b, 1'b0);
      @(negedge aclk);
      check("srst_pre_busy", busy, b == 2);
      next_cycle();
    end
    o_ready = 1'b0;
    srst    = 1'b1;
    drive(2, 1'b1, 64'h303, 1'b0);
    @(negedge aclk);
    check("srst_hold_busy", busy, 1);
    next_cycle();
    srst = 1'b0;
    for (int k = 0; k < N; k++) drive(k, 1'b1, 64'h400 + k, 1'b1);
    o_ready = 1'b1;
    push(0, 64'h400, 1'b1);
    @(negedge aclk);
    check("srst_busy", busy, 0);
    check("srst_grant", o_id, 0);
    next_cycle();
    i_valid = '0;

    // Asynchronous reset mid-burst on stream 2.
    for (int b = 1; b <= 2; b++) push(2, 64'h500 + b, 1'b0);
    for (int b = 1; b <= 2; b++) begin
      drive(2, 1'b1, 64'h500 + b, 1'b0);
      @(negedge aclk);
      check("arst_pre_id", o_id, 2);
      check("arst_pre_busy", busy, b == 2);
      next_cycle();
    end
    i_valid = '0;
    aresetn = 1'b0;
    #1;
    check("arst_o_valid", o_valid, 0);
    check("arst_o_id", o_id, 0);
    check("arst_i_ready", i_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_o_data", o_data, 0);
    next_cycle();
    aresetn = 1'b1;
    for (int k = 0; k < N; k++) drive(k, 1'b1, 64'h600 + k, 1'b1);
    push(0, 64'h600, 1'b1);
    @(negedge aclk);
    check("arst_grant", o_id, 0);
    next_cycle();
    i_valid = '0;

    // Valid gap: stream 3 drops valid for two cycles while stream 0 waits.
    push(3, 64'h701, 1'b0);
    drive(3, 1'b1, 64'h701, 1'b0);
    @(negedge aclk);
    check("gap_first_id", o_id, 3);
    next_cycle();
    drive(3, 1'b0, 64'h0, 1'b0);
    drive(0, 1'b1, 64'h7A0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge aclk);
      check("gap_o_valid", o_valid, 0);
      check("gap_id", o_id, 3);
      check("gap_busy", busy, 1);
      check("gap_ready0", i_ready[0], 0);
      next_cycle();
    end
    push(3, 64'h702, 1'b0);
    push(3, 64'h703, 1'b1);
    push(0, 64'h7A0, 1'b1);
    drive(3, 1'b1, 64'h702, 1'b0);
    @(negedge aclk);
    check("gap_resume_id", o_id, 3);
    next_cycle();
    drive(3, 1'b1, 64'h703, 1'b1);
    @(negedge aclk);
    check("gap_last_id", o_id, 3);
    next_cycle();
    drive(3, 1'b0, 64'h0, 1'b0);
    @(negedge aclk);
    check("gap_next_id", o_id, 0);
    next_cycle();
    i_valid = '0;
    o_ready = 1'b0;

    repeat (2) @(posedge aclk);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
